// File: rtl/forwarding_control_pkg.sv
// Shared forwarding constants for the operand-forwarding control block.
package cpu_fwd_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_SEL_RF  = 2'b00;
  localparam fwd_sel_t FWD_SEL_WB  = 2'b01;
  localparam fwd_sel_t FWD_SEL_MEM = 2'b10;

  localparam int REG_ADDR_W_DFLT = 5;

endpackage

// File: rtl/forwarding_control_if.sv
// ID-side request fields and EX-side forwarding/stall response of the forwarding unit.
interface forwarding_control_if #(parameter int REG_ADDR_W = 5);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_valid;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic [1:0]            select_a;
    logic [1:0]            select_b;
    logic                  stall;

    modport master (
        output id_rs1, id_rs2, id_rd, id_valid, id_reg_write, id_mem_read, flush,
        input  select_a, select_b, stall
    );

    modport slave (
        input  id_rs1, id_rs2, id_rd, id_valid, id_reg_write, id_mem_read, flush,
        output select_a, select_b, stall
    );
endinterface

// File: rtl/fwd_select.sv
// Per-operand forwarding select: picks the youngest in-flight writer of rs.
module fwd_select
    import cpu_fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  ex_valid,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output fwd_sel_t              sel
);
    logic ex_hit, mem_hit;

    assign ex_hit  = ex_valid  && ex_reg_write  && (ex_rd  == rs) && (ex_rd  != '0);
    assign mem_hit = mem_valid && mem_reg_write && (mem_rd == rs) && (mem_rd != '0);

    // EX is younger than MEM, so its result must win
    always_comb begin
        sel = FWD_SEL_RF;
        if (mem_hit) sel = FWD_SEL_WB;
        if (ex_hit)  sel = FWD_SEL_MEM;
    end
endmodule

// File: rtl/forwarding_control.sv
// Forwarding/hazard control: shadow EX/MEM/WB tracking, registered operand selects,
// load-use stall. Optional stall counter port under `FWD_STALL_COUNT_EN.
module forwarding_control
    import cpu_fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
    input  logic                 clk,
    input  logic                 arst_n,
    forwarding_control_if.slave  bus
`ifdef FWD_STALL_COUNT_EN
    ,
    output logic [15:0]          stall_count
`endif
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    stage_t ex_q, mem_q, wb_q, id_stage;
    logic [1:0][REG_ADDR_W-1:0] rs;
    fwd_sel_t [1:0] sel_d, sel_q;
    logic stall, advance;

    assign id_stage = '{valid: 1'b1, rd: bus.id_rd,
                        reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};
    assign rs[0] = bus.id_rs1;
    assign rs[1] = bus.id_rs2;

    // selects are computed against EX/MEM as they stand now, i.e. MEM/WB next cycle
    for (genvar g = 0; g < 2; g++) begin : g_op
        fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
            .rs            (rs[g]),
            .ex_valid      (ex_q.valid),
            .ex_reg_write  (ex_q.reg_write),
            .ex_rd         (ex_q.rd),
            .mem_valid     (mem_q.valid),
            .mem_reg_write (mem_q.reg_write),
            .mem_rd        (mem_q.rd),
            .sel           (sel_d[g])
        );
    end

    // load result is not ready until MEM; flush discards the consumer so no stall
    assign stall = bus.id_valid && !bus.flush && ex_q.valid && ex_q.mem_read &&
                   (ex_q.rd != '0) && ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

    assign advance = bus.id_valid && !bus.flush && !stall;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            sel_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= advance ? id_stage : '0;
            sel_q <= advance ? sel_d : '0;
        end
    end

    assign bus.select_a = sel_q[0];
    assign bus.select_b = sel_q[1];
    assign bus.stall    = stall;

    // WB is tracked for completeness of the shadow pipe but feeds no select today
    logic unused_wb;
    assign unused_wb = ^wb_q;

`ifdef FWD_STALL_COUNT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            stall_count <= '0;
        else if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif
endmodule

// File: doc/forwarding_control.md
FORWARDING_CONTROL -- requirements
Module: forwarding_control

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5: register-address width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-003 SHALL have port arst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports id_rs1, id_rs2, id_rd, input, REG_ADDR_W each: source/destination fields of the instruction in ID.
REQ-005 SHALL have ports id_valid, id_reg_write, id_mem_read, input, 1 each: ID holds a real instruction / writes rd / is a load.
REQ-006 SHALL have port flush, input, 1: taken branch; ID instruction is discarded.
REQ-007 SHALL have ports select_a, select_b, output, 2 each: operand-mux selects for the instruction in EX.
REQ-008 SHALL have port stall, output, 1: hold PC and IF/ID, bubble ID/EX.

Function
REQ-009 SHALL keep internal shadow stages EX, MEM and WB, each holding {valid, rd, reg_write, mem_read}, advancing EX->MEM->WB every cycle.
REQ-010 SHALL define selects as: 2'b00 register-file operand, 2'b01 MEM/WB writeback value, 2'b10 EX/MEM ALU result; 2'b11 is never driven.
REQ-011 SHALL register select_a/select_b on the same edge the ID instruction enters EX, so they are valid for the whole EX cycle (zero added latency).
REQ-012 SHALL compute the select for rs against the stages the instruction will see: current EX stage (becomes MEM) -> 2'b10; else current MEM stage (becomes WB) -> 2'b01; else 2'b00.
REQ-013 SHALL match a stage only when that stage has valid=1, reg_write=1, rd==rs and rd!=0; x0 never forwards.
REQ-014 SHALL give EX-stage match priority over MEM-stage match when both hit.
REQ-015 SHALL assert stall combinationally when id_valid=1 and the current EX stage is a valid load (mem_read=1, rd!=0) whose rd equals id_rs1 or id_rs2.
REQ-016 SHALL, during stall, load a bubble (valid=0, selects 2'b00) into EX; the stalled instruction enters EX next cycle with select 2'b01 for the load operand.
REQ-017 SHALL, when flush=1, load a bubble into EX and deassert stall in that cycle; flush wins over stall.
REQ-018 SHALL treat id_valid=0 as a bubble entering EX.
REQ-019 SHALL never stall more than one consecutive cycle for a single load-use pair.

Reset
REQ-020 SHALL, on arst_n low, immediately clear all stage valid bits, rd fields, and drive select_a=select_b=2'b00, stall=0.
REQ-021 SHALL, on reset mid-operation, discard all in-flight tracking; first instruction after release sees 2'b00 selects.
REQ-022 SHALL release reset without glitching outputs; stall depends only on cleared state plus inputs.

Configuration
REQ-023 SHALL, with FWD_STALL_COUNT_EN defined, add output stall_count (16 bits), reset 0, incrementing each cycle stall=1, saturating at 16'hFFFF.
REQ-024 SHALL, without FWD_STALL_COUNT_EN, omit the stall_count port and counter entirely; all other behaviour identical.

Structure
REQ-025 SHALL place constants FWD_SEL_RF=2'b00, FWD_SEL_WB=2'b01, FWD_SEL_MEM=2'b10 and REG_ADDR_W default in shared package cpu_fwd_pkg.
REQ-026 SHALL instantiate sub-module fwd_select (combinational, one per operand) computing the 2-bit select from one rs and the EX/MEM shadow stages.
REQ-027 SHALL contain shadow-stage registers and stall logic in the top module only.

Verification
REQ-028 SHALL cover: add x5 then add using rs1=x5 back-to-back -> select_a=2'b10 in EX cycle of second, stall=0.
REQ-029 SHALL cover: add x5, nop, add rs2=x5 -> select_b=2'b01; same with x5 written twice (gap 0 and 1) -> 2'b10 priority.
REQ-030 SHALL cover: lw x7 then add rs1=x7 -> stall=1 exactly one cycle, bubble in EX, then select_a=2'b01.
REQ-031 SHALL cover: writer with rd=x0 followed by reader rs1=x0 -> select_a=2'b00, no stall; same for lw x0.
REQ-032 SHALL cover: lw x7 followed by dependent add with flush=1 same cycle -> stall=0, bubble in EX, selects 2'b00.
REQ-033 SHALL cover: arst_n pulsed low with three writers in flight -> outputs 2'b00/0 immediately; with FWD_STALL_COUNT_EN, 3 load-use pairs -> stall_count=3, reset -> 0.
